// File: rtl/cba_gate_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : cba_gate_dispatch
// Description : Gate FIFO and tableau sequencer that feeds conjugation_by_action
//               one gate at a time and chains each result into the next gate.
// Revision    : 1.0 - initial release
// ============================================================================
module cba_gate_dispatch #(
    parameter int NUM_QUBIT   = 4,
    parameter int MAX_VECTOR  = 2**NUM_QUBIT,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [2*NUM_QUBIT-1:0] literals_init_i,
    input  logic [MAX_VECTOR-1:0]  phase_init_i,
    input  logic                   gate_wr_i,
    input  logic [2:0]             gate_type_wr_i,
    input  logic [31:0]            qubit_pos_wr_i,
    input  logic [31:0]            qubit_pos2_wr_i,
    input  logic                   gate_last_wr_i,
    output logic                   gate_full_o,
    output logic [2:0]             gate_type_o,
    output logic [31:0]            qubit_pos_o,
    output logic [31:0]            qubit_pos2_o,
    output logic [2*NUM_QUBIT-1:0] literals_cba_o,
    output logic [MAX_VECTOR-1:0]  phase_cba_o,
    output logic                   valid_cba_o,
    input  logic [2*NUM_QUBIT-1:0] literals_ret_i,
    input  logic [MAX_VECTOR-1:0]  phase_ret_i,
    input  logic                   valid_ret_i,
    output logic [2*NUM_QUBIT-1:0] literals_res_o,
    output logic [MAX_VECTOR-1:0]  phase_res_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [3:0]             err_o
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [c_PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W:0]         count_q, count_d;
    logic [2:0]               mem_type_q [FIFO_DEPTH];
    logic [31:0]              mem_pos_q  [FIFO_DEPTH];
    logic [31:0]              mem_pos2_q [FIFO_DEPTH];
    logic                     mem_last_q [FIFO_DEPTH];

    logic [2:0]               gtype_q, gtype_d;
    logic [31:0]              gpos_q, gpos_d, gpos2_q, gpos2_d;
    logic                     glast_q, glast_d;
    logic [2*NUM_QUBIT-1:0]   lit_q, lit_d, res_lit_q, res_lit_d;
    logic [MAX_VECTOR-1:0]    ph_q, ph_d, res_ph_q, res_ph_d;
    logic [c_CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]               err_q, err_d;
    logic                     ovf_idle_q, ovf_idle_d;

    logic                     w_full, w_empty, w_push, w_pop, w_ovf;
    logic [2:0]               w_head_type;
    logic [31:0]              w_head_pos, w_head_pos2;
    logic                     w_head_last, w_bad_type, w_bad_pos;

    assign w_full      = (count_q == (c_PTR_W+1)'(FIFO_DEPTH));
    assign w_empty     = (count_q == '0);
    assign w_push      = gate_wr_i && !w_full;
    assign w_ovf       = gate_wr_i && w_full;
    assign w_head_type = mem_type_q[rd_ptr_q];
    assign w_head_pos  = mem_pos_q[rd_ptr_q];
    assign w_head_pos2 = mem_pos2_q[rd_ptr_q];
    assign w_head_last = mem_last_q[rd_ptr_q];
    assign w_bad_type  = (w_head_type > 3'd2);
    assign w_bad_pos   = (w_head_pos >= 32'(NUM_QUBIT)) ||
                         ((w_head_type == 3'd2) &&
                          ((w_head_pos2 >= 32'(NUM_QUBIT)) || (w_head_pos == w_head_pos2)));

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_type_q[wr_ptr_q] <= gate_type_wr_i;
            mem_pos_q[wr_ptr_q]  <= qubit_pos_wr_i;
            mem_pos2_q[wr_ptr_q] <= qubit_pos2_wr_i;
            mem_last_q[wr_ptr_q] <= gate_last_wr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            gtype_q    <= '0;
            gpos_q     <= '0;
            gpos2_q    <= '0;
            glast_q    <= 1'b0;
            lit_q      <= '0;
            ph_q       <= '0;
            res_lit_q  <= '0;
            res_ph_q   <= '0;
            cnt_q      <= '0;
            err_q      <= '0;
            ovf_idle_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            gtype_q    <= gtype_d;
            gpos_q     <= gpos_d;
            gpos2_q    <= gpos2_d;
            glast_q    <= glast_d;
            lit_q      <= lit_d;
            ph_q       <= ph_d;
            res_lit_q  <= res_lit_d;
            res_ph_q   <= res_ph_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            ovf_idle_q <= ovf_idle_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gtype_d    = gtype_q;
        gpos_d     = gpos_q;
        gpos2_d    = gpos2_q;
        glast_d    = glast_q;
        lit_d      = lit_q;
        ph_d       = ph_q;
        res_lit_d  = res_lit_q;
        res_ph_d   = res_ph_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        ovf_idle_d = ovf_idle_q;
        w_pop      = 1'b0;

        if (w_ovf) begin
            err_d[2] = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    lit_d      = literals_init_i;
                    ph_d       = phase_init_i;
                    // Overflow while idle lost a gate of the circuit about to run,
                    // so it survives the error clear at start.
                    err_d      = {1'b0, ovf_idle_q | w_ovf, 2'b00};
                    ovf_idle_d = 1'b0;
                    state_d    = S_FETCH;
                end else if (w_ovf) begin
                    ovf_idle_d = 1'b1;
                end
            end
            S_FETCH: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_bad_type) err_d[0] = 1'b1;
                    if (w_bad_pos)  err_d[1] = 1'b1;
                    if (w_bad_type || w_bad_pos) begin
                        if (w_head_last) begin
                            res_lit_d = lit_q;
                            res_ph_d  = ph_q;
                            state_d   = S_DONE;
                        end
                    end else begin
                        gtype_d = w_head_type;
                        gpos_d  = w_head_pos;
                        gpos2_d = w_head_pos2;
                        glast_d = w_head_last;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (valid_ret_i) begin
                    lit_d = literals_ret_i;
                    ph_d  = phase_ret_i;
                    cnt_d = '0;
                    if (glast_q) begin
                        res_lit_d = literals_ret_i;
                        res_ph_d  = phase_ret_i;
                        state_d   = S_DONE;
                    end else begin
                        state_d   = S_FETCH;
                    end
                end else if (cnt_q == c_CNT_W'(TIMEOUT_CYC - 1)) begin
                    err_d[3] = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pointers are exactly c_PTR_W wide, so increment wraps modulo FIFO_DEPTH.
    always_comb begin
        wr_ptr_d = w_push ? wr_ptr_q + c_PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + c_PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + (c_PTR_W+1)'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - (c_PTR_W+1)'(1);
        end
    end

    assign gate_full_o    = w_full;
    assign gate_type_o    = gtype_q;
    assign qubit_pos_o    = gpos_q;
    assign qubit_pos2_o   = gpos2_q;
    assign literals_cba_o = lit_q;
    assign phase_cba_o    = ph_q;
    assign valid_cba_o    = (state_q == S_ISSUE);
    assign literals_res_o = res_lit_q;
    assign phase_res_o    = res_ph_q;
    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = (state_q == S_DONE);
    assign err_o          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cba_gate_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_cba_gate_dispatch
// Description : Scoreboard bench for cba_gate_dispatch with a mock CBA stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cba_gate_dispatch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  literals_init_i = '0;
    logic [15:0] phase_init_i = '0;
    logic        gate_wr_i = 1'b0;
    logic [2:0]  gate_type_wr_i = '0;
    logic [31:0] qubit_pos_wr_i = '0;
    logic [31:0] qubit_pos2_wr_i = '0;
    logic        gate_last_wr_i = 1'b0;
    logic        gate_full_o;
    logic [2:0]  gate_type_o;
    logic [31:0] qubit_pos_o, qubit_pos2_o;
    logic [7:0]  literals_cba_o;
    logic [15:0] phase_cba_o;
    logic        valid_cba_o;
    logic [7:0]  literals_ret_i = '0;
    logic [15:0] phase_ret_i = '0;
    logic        valid_ret_i = 1'b0;
    logic [7:0]  literals_res_o;
    logic [15:0] phase_res_o;
    logic        busy_o, done_o;
    logic [3:0]  err_o;

    cba_gate_dispatch #(
        .NUM_QUBIT(4), .MAX_VECTOR(16), .FIFO_DEPTH(8), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .literals_init_i(literals_init_i), .phase_init_i(phase_init_i),
        .gate_wr_i(gate_wr_i), .gate_type_wr_i(gate_type_wr_i),
        .qubit_pos_wr_i(qubit_pos_wr_i), .qubit_pos2_wr_i(qubit_pos2_wr_i),
        .gate_last_wr_i(gate_last_wr_i), .gate_full_o(gate_full_o),
        .gate_type_o(gate_type_o), .qubit_pos_o(qubit_pos_o), .qubit_pos2_o(qubit_pos2_o),
        .literals_cba_o(literals_cba_o), .phase_cba_o(phase_cba_o), .valid_cba_o(valid_cba_o),
        .literals_ret_i(literals_ret_i), .phase_ret_i(phase_ret_i), .valid_ret_i(valid_ret_i),
        .literals_res_o(literals_res_o), .phase_res_o(phase_res_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  t;
        logic [31:0] p;
        logic [31:0] p2;
        logic [7:0]  l;
        logic [15:0] ph;
    } gexp_t;

    typedef struct packed {
        logic [7:0]  l;
        logic [15:0] ph;
    } rexp_t;

    gexp_t exp_gate_q[$];
    rexp_t exp_res_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int n_vcba = 0;
    int n_done = 0;
    int cyc = 0;
    int ret_cyc = -1;
    int done_cyc = -1;
    bit mock_en = 1'b1;
    int mock_cnt = 0;
    logic [7:0]  mock_lit = '0;
    logic [15:0] mock_ph = '0;
    bit prev_vcba = 1'b0;
    logic [7:0]  pm_lit = '0;
    logic [15:0] pm_ph = '0;

    // Stand-in CBA transform: any deterministic, gate-dependent mixing works.
    function automatic logic [7:0] f_lit(input logic [7:0] l, input logic [2:0] t, input logic [31:0] p);
        return {l[6:0], l[7]} ^ (8'd1 << (2 * p[1:0])) ^ {5'd0, t};
    endfunction

    function automatic logic [15:0] f_ph(input logic [15:0] ph, input logic [2:0] t, input logic [31:0] p2);
        return {ph[14:0], ph[15]} ^ (16'd1 << p2[3:0]) ^ {13'd0, t};
    endfunction

    always @(negedge clk) begin
        gexp_t g;
        rexp_t r;
        cyc++;
        if (valid_cba_o) begin
            n_vcba++;
            n_checks++;
            if (prev_vcba) begin
                n_errors++;
                $display("FAIL vcba_pulse: valid_cba high %0d cycles, required 1", 2);
            end
            n_checks++;
            if (exp_gate_q.size() == 0) begin
                n_errors++;
                $display("FAIL vcba_unexpected: got valid_cba, required none");
            end else begin
                g = exp_gate_q.pop_front();
                if ({gate_type_o, qubit_pos_o, qubit_pos2_o} !== {g.t, g.p, g.p2}) begin
                    n_errors++;
                    $display("FAIL gate_fields: got %0d/%0d/%0d required %0d/%0d/%0d",
                             gate_type_o, qubit_pos_o, qubit_pos2_o, g.t, g.p, g.p2);
                end
                n_checks++;
                if (literals_cba_o !== g.l || phase_cba_o !== g.ph) begin
                    n_errors++;
                    $display("FAIL cba_tableau: got %h/%h required %h/%h",
                             literals_cba_o, phase_cba_o, g.l, g.ph);
                end
            end
        end
        prev_vcba = valid_cba_o;

        if (done_o) begin
            n_done++;
            done_cyc = cyc;
            n_checks++;
            if (exp_res_q.size() == 0) begin
                n_errors++;
                $display("FAIL done_unexpected: got done, required none");
            end else begin
                r = exp_res_q.pop_front();
                if (literals_res_o !== r.l || phase_res_o !== r.ph) begin
                    n_errors++;
                    $display("FAIL result: got %h/%h required %h/%h",
                             literals_res_o, phase_res_o, r.l, r.ph);
                end
            end
        end

        valid_ret_i = 1'b0;
        if (mock_cnt > 0) begin
            mock_cnt--;
            if (mock_cnt == 0) begin
                valid_ret_i    = 1'b1;
                literals_ret_i = mock_lit;
                phase_ret_i    = mock_ph;
                ret_cyc        = cyc;
            end
        end
        if (valid_cba_o && mock_en) begin
            mock_lit = f_lit(literals_cba_o, gate_type_o, qubit_pos_o);
            mock_ph  = f_ph(phase_cba_o, gate_type_o, qubit_pos2_o);
            mock_cnt = 5;
        end
    end

    task automatic set_init(input logic [7:0] l, input logic [15:0] ph);
        literals_init_i = l;
        phase_init_i    = ph;
        pm_lit          = l;
        pm_ph           = ph;
    endtask

    task automatic push_gate(input logic [2:0] t, input logic [31:0] p, input logic [31:0] p2,
                             input bit last, input bit model);
        bit good;
        @(negedge clk);
        gate_wr_i       = 1'b1;
        gate_type_wr_i  = t;
        qubit_pos_wr_i  = p;
        qubit_pos2_wr_i = p2;
        gate_last_wr_i  = last;
        @(posedge clk);
        #1 gate_wr_i = 1'b0;
        if (model) begin
            good = (t <= 3'd2) && (p < 32'd4) && ((t != 3'd2) || ((p2 < 32'd4) && (p != p2)));
            if (good) begin
                exp_gate_q.push_back('{t: t, p: p, p2: p2, l: pm_lit, ph: pm_ph});
                pm_lit = f_lit(pm_lit, t, p);
                pm_ph  = f_ph(pm_ph, t, p2);
            end
            if (last) exp_res_q.push_back('{l: pm_lit, ph: pm_ph});
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_o) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s_done_timeout: no done within %0d cycles", tag, budget);
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_gate_q.delete();
        exp_res_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bit seen = 1'b0;
        set_init(8'h3C, 16'hBEEF);
        push_gate(3'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        pulse_start();
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = valid_cba_o;
        end
        repeat (2) @(negedge clk);
        apply_reset();
        n_checks++;
        if (busy_o !== 1'b0 || gate_full_o !== 1'b0 || err_o !== 4'd0 ||
            valid_cba_o !== 1'b0 || done_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: busy=%b full=%b err=%b vcba=%b done=%b required all 0",
                     busy_o, gate_full_o, err_o, valid_cba_o, done_o);
        end
        n_checks++;
        if ({literals_cba_o, phase_cba_o, literals_res_o, phase_res_o, gate_type_o,
             qubit_pos_o, qubit_pos2_o} !== '0) begin
            n_errors++;
            $display("FAIL reset_data: cba=%h/%h res=%h/%h required 0",
                     literals_cba_o, phase_cba_o, literals_res_o, phase_res_o);
        end
        n_done = 0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b0 || n_done != 0 || literals_cba_o !== 8'h00 || literals_res_o !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_stale_ret: busy=%b done_count=%0d cba=%h res=%h required 0/0/00/00",
                     busy_o, n_done, literals_cba_o, literals_res_o);
        end
    endtask

    task automatic test_single_h();
        n_vcba = 0;
        n_done = 0;
        set_init(8'hA5, 16'h1234);
        push_gate(3'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        pulse_start();
        wait_done(100, "single");
        n_checks++;
        if (n_vcba != 1 || n_done != 1) begin
            n_errors++;
            $display("FAIL single_counts: vcba=%0d done=%0d required 1/1", n_vcba, n_done);
        end
        n_checks++;
        if (done_cyc - ret_cyc != 1) begin
            n_errors++;
            $display("FAIL single_latency: done %0d cycles after valid_ret, required 1",
                     done_cyc - ret_cyc);
        end
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_errors++;
            $display("FAIL single_busy: got %b required 0", busy_o);
        end
    endtask

    task automatic test_chain();
        n_vcba = 0;
        n_done = 0;
        set_init(8'h5A, 16'hC3C3);
        push_gate(3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        push_gate(3'd2, 32'd0, 32'd1, 1'b0, 1'b1);
        push_gate(3'd1, 32'd1, 32'd0, 1'b1, 1'b1);
        pulse_start();
        wait_done(200, "chain");
        repeat (3) @(negedge clk);
        n_checks++;
        if (n_vcba != 3 || n_done != 1) begin
            n_errors++;
            $display("FAIL chain_counts: vcba=%0d done=%0d required 3/1", n_vcba, n_done);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        n_vcba = 0;
        n_done = 0;
        set_init(8'h0F, 16'h00F0);
        for (int i = 0; i < 8; i++) begin
            push_gate(3'(i % 3), 32'(i % 4), 32'((i + 1) % 4), (i == 7), 1'b1);
        end
        @(negedge clk);
        n_checks++;
        if (gate_full_o !== 1'b1 || err_o !== 4'd0) begin
            n_errors++;
            $display("FAIL ovf_full: full=%b err=%b required 1/0000", gate_full_o, err_o);
        end
        push_gate(3'd1, 32'd3, 32'd0, 1'b1, 1'b0);
        pulse_start();
        n_checks++;
        if (err_o !== 4'b0100) begin
            n_errors++;
            $display("FAIL ovf_err_after_start: got %b required 0100", err_o);
        end
        wait_done(400, "ovf");
        n_checks++;
        if (n_vcba != 8 || n_done != 1 || gate_full_o !== 1'b0 || err_o !== 4'b0100) begin
            n_errors++;
            $display("FAIL ovf_drain: vcba=%0d done=%0d full=%b err=%b required 8/1/0/0100",
                     n_vcba, n_done, gate_full_o, err_o);
        end
    endtask

    task automatic test_bad_entries();
        n_vcba = 0;
        n_done = 0;
        set_init(8'h96, 16'h7E81);
        push_gate(3'd5, 32'd0, 32'd0, 1'b0, 1'b1);
        push_gate(3'd2, 32'd2, 32'd2, 1'b1, 1'b1);
        pulse_start();
        wait_done(50, "bad");
        n_checks++;
        if (n_vcba != 0 || n_done != 1 || err_o !== 4'b0011) begin
            n_errors++;
            $display("FAIL bad_entries: vcba=%0d done=%0d err=%b required 0/1/0011",
                     n_vcba, n_done, err_o);
        end
    endtask

    task automatic test_timeout();
        bit seen = 1'b0;
        int k = 0;
        mock_en = 1'b0;
        n_done = 0;
        set_init(8'h11, 16'h2222);
        push_gate(3'd0, 32'd1, 32'd0, 1'b1, 1'b1);
        pulse_start();
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = valid_cba_o;
        end
        while (busy_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k != 17) begin
            n_errors++;
            $display("FAIL timeout_len: busy dropped %0d cycles after issue, required 17", k);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (err_o !== 4'b1000 || n_done != 0 || busy_o !== 1'b0 || literals_cba_o !== 8'h11) begin
            n_errors++;
            $display("FAIL timeout_state: err=%b done=%0d busy=%b cba=%h required 1000/0/0/11",
                     err_o, n_done, busy_o, literals_cba_o);
        end
        exp_res_q.delete();
        mock_en = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_single_h();
        test_chain();
        test_overflow();
        test_bad_entries();
        test_timeout();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
